seq_mult: RTL and testbench
===========================

Name: seq_mult

Overview:
- Parametrised iterative multiplier: A_W x B_W operands, signed or unsigned selected per operation, STEP multiplier bits retired per cycle.
- Result width is A_W+B_W.
- Successor to the fixed-size combinational partial-product/adder-tree multipliers; trades latency for area.
- Sits between a valid/ready producer and consumer; one operation in flight.

Parameters:
- A_W, 8, multiplicand width (>=2)
- B_W, 8, multiplier width (>=2)
- STEP, 1, multiplier bits consumed per CALC cycle; must divide B_W (elaboration error otherwise)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand valid
- in_ready  output  1  block can accept operands
- in_a  input  A_W  multiplicand
- in_b  input  B_W  multiplier
- in_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  A_W+B_W  product
- busy  output  1  high in CALC or DONE

Behaviour:
- Reset is synchronous on rst=1 at a clk edge. It forces IDLE and takes priority over everything, including mid-CALC and DONE. Outputs after reset: in_ready=1, out_valid=0, out_data=0, busy=0, internal registers 0.
- States are IDLE, CALC and DONE. in_ready = (state==IDLE); busy = !IDLE.
- IDLE: on in_valid&&in_ready:
  - latch mag_a=|in_a|, mag_b=|in_b|, neg=in_signed&&(sign_a^sign_b); acc=0; iteration count ITER=B_W/STEP.
  - Magnitudes are computed in the operand width as unsigned, so the most-negative value maps to 2^(W-1).
  - When in_signed=0, mag=raw operand and neg=0.
  - Go to CALC.
- CALC, each edge:
  - acc += (mag_a * mag_b[STEP-1:0]) << (STEP*k), with k the iteration index from 0.
  - mag_b >>= STEP.
  - Arithmetic is unsigned, A_W+B_W wide; no overflow is possible.
- Final CALC edge:
  - Load out_data = neg ? -acc_next : acc_next, truncated to A_W+B_W, where acc_next includes the final iteration.
  - Set out_valid=1 and go to DONE.
- Latency: accept at edge E0 gives out_valid high after edge E0+ITER. A_W=B_W=8, STEP=1: 8 cycles. STEP=2: 4 cycles.
- DONE:
  - out_data and out_valid hold stable while out_ready=0, indefinitely.
  - On out_valid&&out_ready: out_valid=0 and go to IDLE. out_data keeps its last value.
  - in_ready is 0 in DONE, so there is no same-cycle accept. The minimum spacing between accepts is ITER+2 cycles.
- in_valid or operand changes outside IDLE are ignored. Operands are captured only at the accept edge.
- Signed range: (-2^(A_W-1))*(-2^(B_W-1)) = 2^(A_W+B_W-2) fits. Every product is exact in A_W+B_W bits for both modes.
- out_ready asserted while not in DONE has no effect.

Optional Feature:
- Macro SEQ_MULT_EARLY_TERM_EN.
- Defined: in CALC, if mag_b after the shift is zero, that edge is treated as final: load result, go to DONE.
  - Latency = max(1, ceil(bitlen(mag_b)/STEP)) cycles.
  - in_b=0 completes in 1 cycle.
  - Results are identical to the non-early-term build.
- Undefined: fixed ITER cycles for every operation. No zero-detect logic is built.

Test Plan:
- Unsigned, defaults: a=255, b=255, in_signed=0 -> out_data=0xFE01 with out_valid after exactly 8 edges; in_ready=0 and busy=1 throughout.
- Signed, defaults: (-128)*(-128) -> 0x4000. (-3)*5 -> 0xFFF1. 127*(-128) -> 0xC080. Back-to-back accepts are spaced 10 cycles with out_ready=1.
- A_W=2, B_W=3, STEP=1, signed: (-2)*3 -> 5-bit 0x1A after 3 edges. Unsigned 3*7 -> 0x15.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, and in_valid pulses are ignored. Raise out_ready -> one-cycle handshake, then IDLE.
- Reset mid-CALC (rst at cycle 3 of 8) -> next cycle: in_ready=1, out_valid=0, out_data=0. A new op 6*7 unsigned -> 0x002A.
- STEP=2, defaults: 200*3 -> 0x0258 after 4 edges. With SEQ_MULT_EARLY_TERM_EN: b=1 -> 1 edge; b=0 -> 0x0000 after 1 edge; b=0x80 -> 4 edges.

Source files
------------

// File: rtl/seq_mult.sv
// seq_mult: iterative shift-and-add multiplier behind valid/ready handshakes.
//   Operands are converted to magnitudes at accept. STEP multiplier bits are
//   retired per CALC cycle. The sign is applied once, when the result is loaded.
//   Only one operation is in flight at a time.
//
// Parameters:
//   A_W  - multiplicand width (>= 2)
//   B_W  - multiplier width (>= 2)
//   STEP - multiplier bits consumed per CALC cycle; must divide B_W
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   in_valid  in   operand valid
//   in_ready  out  block can accept operands (IDLE)
//   in_a      in   [A_W-1:0] multiplicand
//   in_b      in   [B_W-1:0] multiplier
//   in_signed in   1 = two's-complement operands, 0 = unsigned
//   out_valid out  result valid
//   out_ready in   consumer accepts result
//   out_data  out  [A_W+B_W-1:0] product
//   busy      out  high in CALC or DONE
//
// Optional feature (macro SEQ_MULT_EARLY_TERM_EN):
//   When the macro is defined, CALC ends as soon as the remaining multiplier
//   magnitude is zero. Without the macro, every operation takes B_W/STEP cycles.
module seq_mult #(
  parameter int unsigned A_W  = 8,
  parameter int unsigned B_W  = 8,
  parameter int unsigned STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       in_a,
  input  logic [B_W-1:0]       in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_W+B_W-1:0]   out_data,
  output logic                 busy
);

  localparam int unsigned P_W    = A_W + B_W;
  localparam int unsigned STEP_G = (STEP == 0) ? 1 : STEP;
  localparam int unsigned ITER   = B_W / STEP_G;
  localparam int unsigned CNT_W  = (ITER > 1) ? $clog2(ITER) : 1;

  // Reject configurations where the multiplier cannot be split evenly.
  if ((STEP == 0) || ((B_W % STEP_G) != 0) || (A_W < 2) || (B_W < 2)) begin : g_param_check
    $error("seq_mult: STEP must be nonzero and divide B_W; A_W and B_W must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [P_W-1:0]   mcand;   // |a| pre-shifted to the weight of the current digit
  logic [P_W-1:0]   acc;
  logic [B_W-1:0]   mag_b;   // remaining multiplier magnitude bits
  logic             neg;
  logic [CNT_W-1:0] cnt;

  // Operand magnitudes, taken in operand width so the most-negative value maps to 2^(W-1)
  logic [A_W-1:0] abs_a;
  logic [B_W-1:0] abs_b;
  logic           neg_in;

  assign abs_a  = (in_signed && in_a[A_W-1]) ? (~in_a + A_W'(1)) : in_a;
  assign abs_b  = (in_signed && in_b[B_W-1]) ? (~in_b + B_W'(1)) : in_b;
  assign neg_in = in_signed && (in_a[A_W-1] ^ in_b[B_W-1]);

  // One digit's worth of partial product and the updated accumulator
  logic [STEP_G-1:0] digit;
  logic [P_W-1:0]    partial;
  logic [P_W-1:0]    acc_next;
  logic [B_W-1:0]    mag_b_next;
  logic [P_W-1:0]    result;
  logic              last_iter;

  assign digit      = mag_b[STEP_G-1:0];
  assign partial    = mcand * P_W'(digit);
  assign acc_next   = acc + partial;
  assign mag_b_next = mag_b >> STEP_G;
  assign result     = neg ? (~acc_next + P_W'(1)) : acc_next;

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Nothing left to add once the remaining multiplier bits are all zero
  assign last_iter = (cnt == CNT_W'(ITER - 1)) || (mag_b_next == '0);
`else
  assign last_iter = (cnt == CNT_W'(ITER - 1));
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      mcand     <= '0;
      acc       <= '0;
      mag_b     <= '0;
      neg       <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mcand    <= P_W'(abs_a);
            mag_b    <= abs_b;
            neg      <= neg_in;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_CALC;
          end
        end

        S_CALC: begin
          acc   <= acc_next;
          mag_b <= mag_b_next;
          mcand <= mcand << STEP_G;
          cnt   <= cnt + CNT_W'(1);
          if (last_iter) begin
            out_data  <= result;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          // Result holds until the consumer takes it; out_data keeps its value afterwards
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Directed, table-driven bench for seq_mult. It instantiates three configurations:
// 8x8 with STEP=1, 2x3 with STEP=1 and 8x8 with STEP=2.
module tb_seq_mult;

  logic        clk;
  logic        rst;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_signed;
  logic        out_ready;
  logic [2:0]  v;
  logic [2:0]  ir;
  logic [2:0]  ov;
  logic [2:0]  by;
  logic [15:0] od0;
  logic [4:0]  od1;
  logic [15:0] od2;

  int cyc;
  int n_pass;
  int n_total;

  seq_mult #(.A_W(8), .B_W(8), .STEP(1)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(v[0]), .in_ready(ir[0]),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0), .busy(by[0])
  );

  seq_mult #(.A_W(2), .B_W(3), .STEP(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(v[1]), .in_ready(ir[1]),
    .in_a(in_a[1:0]), .in_b(in_b[2:0]), .in_signed(in_signed),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1), .busy(by[1])
  );

  seq_mult #(.A_W(8), .B_W(8), .STEP(2)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(v[2]), .in_ready(ir[2]),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od2), .busy(by[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          sel;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic logic [15:0] od_of(input int sel);
    if (sel == 0) return od0;
    if (sel == 1) return 16'(od1);
    return od2;
  endfunction

  // Expected latency from the multiplier magnitude and the configuration
  function automatic int exp_lat(input int sel, input logic [7:0] b, input logic sgn);
    int bw;
    int st;
    int bb;
    int mb;
    int bl;
    int l;
    bw = (sel == 1) ? 3 : 8;
    st = (sel == 2) ? 2 : 1;
    bb = int'(b) & ((1 << bw) - 1);
    mb = (sgn && (((bb >> (bw - 1)) & 1) == 1)) ? ((1 << bw) - bb) : bb;
    bl = 0;
    l  = bw / st;
`ifdef SEQ_MULT_EARLY_TERM_EN
    for (int i = 0; i < bw; i++) if (((mb >> i) & 1) == 1) bl = i + 1;
    l = (bl + st - 1) / st;
    if (l < 1) l = 1;
`else
    if (bl != 0 || mb < 0) l = bw / st;
`endif
    return l;
  endfunction

  // Present operands and hold in_valid through one edge; returns accept cycle
  task automatic start_op(input int sel, input logic [7:0] a, input logic [7:0] b,
                          input logic sgn, output int acc_cyc);
    in_a = a;
    in_b = b;
    in_signed = sgn;
    v[sel] = 1'b1;
    @(posedge clk);
    #1;
    v[sel] = 1'b0;
    acc_cyc = cyc;
  endtask

  // Count edges until out_valid, watching in_ready/busy on the way (bounded)
  task automatic wait_done(input int sel, output int n, output bit ok);
    n = 0;
    ok = 1'b1;
    while (!ov[sel] && n < 40) begin
      if (!by[sel] || ir[sel]) ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int   acc_c;
    int   prev_c;
    int   prev_lat;
    int   n;
    int   lat;
    bit   ok;
    bit   stable;

    cyc = 0;
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    v = 3'b000;
    in_a = '0;
    in_b = '0;
    in_signed = 1'b0;
    out_ready = 1'b1;

    vecs[0]  = '{0, 8'd255, 8'd255, 1'b0, 16'hFE01};
    vecs[1]  = '{0, 8'h80,  8'h80,  1'b1, 16'h4000};
    vecs[2]  = '{0, 8'hFD,  8'h05,  1'b1, 16'hFFF1};
    vecs[3]  = '{0, 8'h7F,  8'h80,  1'b1, 16'hC080};
    vecs[4]  = '{0, 8'h80,  8'h80,  1'b0, 16'h4000};
    vecs[5]  = '{0, 8'h00,  8'hFF,  1'b1, 16'h0000};
    vecs[6]  = '{0, 8'hFF,  8'hFF,  1'b1, 16'h0001};
    vecs[7]  = '{1, 8'h02,  8'h03,  1'b1, 16'h001A};
    vecs[8]  = '{1, 8'h03,  8'h07,  1'b0, 16'h0015};
    vecs[9]  = '{1, 8'h02,  8'h04,  1'b1, 16'h0008};
    vecs[10] = '{2, 8'd200, 8'd3,   1'b0, 16'h0258};
    vecs[11] = '{2, 8'd200, 8'd1,   1'b0, 16'h00C8};
    vecs[12] = '{2, 8'd200, 8'd0,   1'b0, 16'h0000};
    vecs[13] = '{2, 8'd5,   8'h80,  1'b0, 16'h0280};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    for (int s = 0; s < 3; s++) begin
      check($sformatf("reset_in_ready[%0d]", s), 32'(ir[s]), 32'd1);
      check($sformatf("reset_out_valid[%0d]", s), 32'(ov[s]), 32'd0);
      check($sformatf("reset_busy[%0d]", s), 32'(by[s]), 32'd0);
      check($sformatf("reset_out_data[%0d]", s), 32'(od_of(s)), 32'd0);
    end

    prev_c = 0;
    prev_lat = 0;
    for (int i = 0; i < 14; i++) begin
      lat = exp_lat(vecs[i].sel, vecs[i].b, vecs[i].sgn);
      start_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].sgn, acc_c);
      if (i > 0) check($sformatf("spacing[%0d]", i), 32'(acc_c - prev_c), 32'(prev_lat + 2));
      wait_done(vecs[i].sel, n, ok);
      check($sformatf("latency[%0d]", i), 32'(n), 32'(lat));
      check($sformatf("busy_not_ready[%0d]", i), 32'(ok), 32'd1);
      check($sformatf("product[%0d]", i), 32'(od_of(vecs[i].sel)), 32'(vecs[i].exp));
      @(posedge clk);
      #1;
      check($sformatf("handshake[%0d]", i), {30'd0, ov[vecs[i].sel], ir[vecs[i].sel]}, 32'd1);
      prev_c = acc_c;
      prev_lat = lat;
    end

    // Backpressure: result holds and new operands are ignored while out_ready is low
    out_ready = 1'b0;
    start_op(0, 8'd12, 8'd11, 1'b0, acc_c);
    wait_done(0, n, ok);
    check("bp_latency", 32'(n), 32'(exp_lat(0, 8'd11, 1'b0)));
    check("bp_product", 32'(od0), 32'h0084);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      v[0] = 1'b1;
      in_a = 8'($urandom);
      in_b = 8'($urandom);
      @(posedge clk);
      #1;
      if (!ov[0] || ir[0] || !by[0] || od0 !== 16'h0084) stable = 1'b0;
    end
    v[0] = 1'b0;
    check("bp_hold_stable", 32'(stable), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(ov[0]), 32'd0);
    check("bp_release_ready", 32'(ir[0]), 32'd1);
    check("bp_data_kept", 32'(od0), 32'h0084);
    @(posedge clk);
    #1;
    check("bp_idle_no_accept", 32'(by[0]), 32'd0);

    // Reset in the middle of CALC
    start_op(0, 8'd255, 8'd255, 1'b0, acc_c);
    repeat (2) @(posedge clk);
    #1;
    check("pre_reset_busy", 32'(by[0]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midcalc_reset_ready", 32'(ir[0]), 32'd1);
    check("midcalc_reset_valid", 32'(ov[0]), 32'd0);
    check("midcalc_reset_data", 32'(od0), 32'd0);
    check("midcalc_reset_busy", 32'(by[0]), 32'd0);
    start_op(0, 8'd6, 8'd7, 1'b0, acc_c);
    wait_done(0, n, ok);
    check("after_reset_latency", 32'(n), 32'(exp_lat(0, 8'd7, 1'b0)));
    check("after_reset_product", 32'(od0), 32'h002A);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
